sa2_wb_cache: RTL and testbench
===============================

// Module: sa2_wb_cache
// PURPOSE
// 2-way set-associative, write-back, write-allocate cache. It sits between one CPU request port
//   and one memory port and transfers whole lines; it replaces the 8-line direct-mapped cache.
// New over direct-mapped: parametrised set count, LRU replacement, dirty-victim writeback before refill,
//   write miss without fetch, a response handshake for every request, and saturating hit/miss counters.
// PARAMETERS
// ADDRESS_WIDTH  64   byte address width
// LINE_BITS      512  line width = CPU/memory data width
// OFFSET_BITS    6    byte-offset bits within a line; ignored on input, zeroed on memory addresses
// SET_BITS       3    set index bits; there are 2**SET_BITS sets, each with 2 ways
// CNT_WIDTH      32   width of the statistics counters
// PORTS
// clk               in   1              clock, rising edge
// rst_n             in   1              asynchronous active-low reset
// i_cpu_req_valid   in   1              CPU request valid
// o_cpu_req_ready   out  1              cache can accept a request
// i_cpu_rd_wr       in   1              0 = read, 1 = write
// i_cpu_address     in   ADDRESS_WIDTH  request address
// i_cpu_write_data  in   LINE_BITS      full-line write data
// o_cpu_resp_valid  out  1              response valid
// i_cpu_resp_ready  in   1              CPU accepts the response
// o_cpu_read_data   out  LINE_BITS      read data; for a write, echoes the written line
// o_mem_valid       out  1              memory request valid
// i_mem_ready       in   1              memory accepts the request
// o_mem_rd_wr       out  1              0 = line read, 1 = line writeback
// o_mem_address     out  ADDRESS_WIDTH  line-aligned memory address
// o_mem_write_data  out  LINE_BITS      writeback data
// i_mem_read_valid  in   1              refill data valid
// o_mem_read_ready  out  1              cache ready for refill data
// i_mem_read_data   in   LINE_BITS      refill data
// o_hit_count       out  CNT_WIDTH      saturating count of hits
// o_miss_count      out  CNT_WIDTH      saturating count of misses
// BEHAVIOUR
// Reset (async, immediate): all outputs 0. All valid, dirty and LRU bits, tags and counters cleared.
//   Reset mid-transaction abandons the transaction; no memory or CPU handshake completes afterwards.
// Address split: tag = addr[AW-1:OFFSET_BITS+SET_BITS], set = addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS].
// FSM states: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESP.
// IDLE: o_cpu_req_ready=1 only in this state. On valid&&ready, register rd_wr, address and wdata -> LOOKUP.
// LOOKUP (one cycle): a way hits when its valid bit is set and its tag matches.
//   Hit: read returns the line; write replaces the line and sets dirty. LRU[set] <= other way. hit_count++.
//   Go to RESP. Hit latency: request accepted at cycle T, o_cpu_resp_valid=1 at T+2.
//   Miss: miss_count++. Victim = way0 if invalid, else way1 if invalid, else way LRU[set].
//   If the victim is valid and dirty -> WRITEBACK. Else a read goes to REFILL_REQ and a write installs
//   directly (tag, valid=1, dirty=1, data=wdata, LRU flipped) and goes to RESP.
// WRITEBACK: o_mem_valid=1, rd_wr=1, address={victim tag,set,0}, data=victim line.
//   All of these hold stable until i_mem_ready. Then a read -> REFILL_REQ; a write installs as above -> RESP.
// REFILL_REQ: o_mem_valid=1, rd_wr=0, address={tag,set,0}, held until i_mem_ready -> REFILL_WAIT.
// REFILL_WAIT: o_mem_read_ready=1. On i_mem_read_valid, install line (valid=1, dirty=0), LRU[set] <= other way,
//   o_cpu_read_data=refill data -> RESP. Refill data returned while in REFILL_REQ is not accepted.
// RESP: o_cpu_resp_valid=1 and o_cpu_read_data held stable until i_cpu_resp_ready -> IDLE.
// o_mem_valid drops in the cycle after the accepting handshake. Exactly one response per accepted request.
// Counters saturate at 2**CNT_WIDTH-1 and never wrap.
// TESTING (SET_BITS=3, OFFSET_BITS=6; 0x1040/0x1240/0x1440/0x1640 all map to set 1, tags 8/9/A/B)
// 1 Cold read 0x1040 -> mem read to 0x1040; return D1 -> resp D1, miss=1; reread -> resp at T+2, no mem traffic, hit=1.
// 2 Write 0x1240 with D2 -> installs in way1 with no mem traffic, resp echoes D2; reread 0x1040 -> still a hit with D1.
// 3 Reread 0x1240 (LRU -> way0), then read 0x1440 -> evicts clean 0x1040 with no writeback, mem read 0x1440 only.
// 4 Then read 0x1640 -> mem write 0x1240 with D2 first, then mem read 0x1640; reread 0x1440 hits.
// 5 Backpressure: i_mem_ready=0 and i_cpu_resp_ready=0 for 5 cycles -> mem and resp outputs stable, req_ready=0.
// 6 rst_n low in REFILL_WAIT -> all outputs 0 immediately; read 0x1040 then misses. With CNT_WIDTH=4, 20 hits -> hit=15.

Source files
------------

// File: rtl/sa2_wb_cache.sv
// 2-way set-associative write-back / write-allocate cache with whole-line CPU and memory ports.
// LRU replacement per set, dirty-victim writeback before refill, and saturating hit/miss counters.
module sa2_wb_cache #(
  parameter int unsigned ADDRESS_WIDTH = 64,
  parameter int unsigned LINE_BITS     = 512,
  parameter int unsigned OFFSET_BITS   = 6,
  parameter int unsigned SET_BITS      = 3,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cpu_req_valid,
  output logic                     o_cpu_req_ready,
  input  logic                     i_cpu_rd_wr,
  input  logic [ADDRESS_WIDTH-1:0] i_cpu_address,
  input  logic [LINE_BITS-1:0]     i_cpu_write_data,
  output logic                     o_cpu_resp_valid,
  input  logic                     i_cpu_resp_ready,
  output logic [LINE_BITS-1:0]     o_cpu_read_data,
  output logic                     o_mem_valid,
  input  logic                     i_mem_ready,
  output logic                     o_mem_rd_wr,
  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic [LINE_BITS-1:0]     o_mem_write_data,
  input  logic                     i_mem_read_valid,
  output logic                     o_mem_read_ready,
  input  logic [LINE_BITS-1:0]     i_mem_read_data,
  output logic [CNT_WIDTH-1:0]     o_hit_count,
  output logic [CNT_WIDTH-1:0]     o_miss_count
);

  localparam int unsigned TagBits  = ADDRESS_WIDTH - OFFSET_BITS - SET_BITS;
  localparam int unsigned LineAddr = ADDRESS_WIDTH - OFFSET_BITS;
  localparam int unsigned NumSets  = 2 ** SET_BITS;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    StIdle, StLookup, StWriteback, StRefillReq, StRefillWait, StResp
  } state_e;

  state_e                 state_q, state_d;
  logic                   rd_wr_q, rd_wr_d;
  logic [LineAddr-1:0]    laddr_q, laddr_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic                   victim_q, victim_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   mem_valid_q, mem_valid_d;
  logic                   mem_rd_wr_q, mem_rd_wr_d;
  logic                   mem_read_ready_q, mem_read_ready_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_BITS-1:0]   resp_data_q, resp_data_d;
  logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;

  logic [TagBits-1:0]     tag_q   [2][NumSets];
  logic [LINE_BITS-1:0]   data_q  [2][NumSets];
  logic [NumSets-1:0]     valid_q [2];
  logic [NumSets-1:0]     dirty_q [2];
  logic [NumSets-1:0]     lru_q;

  logic [SET_BITS-1:0]    req_set;
  logic [TagBits-1:0]     req_tag;
  logic                   hit0, hit1, hit, hit_way;
  logic                   miss_victim, victim_dirty;
  logic                   upd_en, upd_way, upd_dirty, lru_en, lru_way;
  logic [LINE_BITS-1:0]   upd_data;
  logic                   unused_offset;

  assign unused_offset = ^i_cpu_address[OFFSET_BITS-1:0];

  assign req_set = laddr_q[SET_BITS-1:0];
  assign req_tag = laddr_q[LineAddr-1:SET_BITS];
  assign hit0    = valid_q[0][req_set] && (tag_q[0][req_set] == req_tag);
  assign hit1    = valid_q[1][req_set] && (tag_q[1][req_set] == req_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = ~hit0;

  // Fill empty ways first; only fall back to LRU once both ways of the set are valid.
  assign miss_victim  = !valid_q[0][req_set] ? 1'b0 :
                        !valid_q[1][req_set] ? 1'b1 : lru_q[req_set];
  assign victim_dirty = valid_q[miss_victim][req_set] && dirty_q[miss_victim][req_set];

  always_comb begin
    state_d     = state_q;
    rd_wr_d     = rd_wr_q;
    laddr_d     = laddr_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_data_d = resp_data_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    upd_en      = 1'b0;
    upd_way     = victim_q;
    upd_dirty   = 1'b1;
    upd_data    = wdata_q;
    lru_en      = 1'b0;
    lru_way     = victim_q;
    unique case (state_q)
      StIdle: begin
        if (i_cpu_req_valid && req_ready_q) begin
          rd_wr_d = i_cpu_rd_wr;
          laddr_d = i_cpu_address[ADDRESS_WIDTH-1:OFFSET_BITS];
          wdata_d = i_cpu_write_data;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          if (hit_cnt_q != CntMax) hit_cnt_d = hit_cnt_q + CntOne;
          lru_en  = 1'b1;
          lru_way = hit_way;
          if (rd_wr_q) begin
            upd_en      = 1'b1;
            upd_way     = hit_way;
            resp_data_d = wdata_q;
          end else begin
            resp_data_d = data_q[hit_way][req_set];
          end
          state_d = StResp;
        end else begin
          if (miss_cnt_q != CntMax) miss_cnt_d = miss_cnt_q + CntOne;
          victim_d = miss_victim;
          if (victim_dirty) begin
            mem_addr_d  = {tag_q[miss_victim][req_set], req_set, {OFFSET_BITS{1'b0}}};
            mem_wdata_d = data_q[miss_victim][req_set];
            state_d     = StWriteback;
          end else if (!rd_wr_q) begin
            mem_addr_d = {laddr_q, {OFFSET_BITS{1'b0}}};
            state_d    = StRefillReq;
          end else begin
            // Full-line write miss: no fetch needed, install straight into the victim way.
            upd_en      = 1'b1;
            upd_way     = miss_victim;
            lru_en      = 1'b1;
            lru_way     = miss_victim;
            resp_data_d = wdata_q;
            state_d     = StResp;
          end
        end
      end
      StWriteback: begin
        if (i_mem_ready) begin
          if (!rd_wr_q) begin
            mem_addr_d = {laddr_q, {OFFSET_BITS{1'b0}}};
            state_d    = StRefillReq;
          end else begin
            upd_en      = 1'b1;
            lru_en      = 1'b1;
            resp_data_d = wdata_q;
            state_d     = StResp;
          end
        end
      end
      StRefillReq: begin
        if (i_mem_ready) state_d = StRefillWait;
      end
      StRefillWait: begin
        if (i_mem_read_valid) begin
          upd_en      = 1'b1;
          upd_dirty   = 1'b0;
          upd_data    = i_mem_read_data;
          lru_en      = 1'b1;
          resp_data_d = i_mem_read_data;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (i_cpu_resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    req_ready_d      = (state_d == StIdle);
    resp_valid_d     = (state_d == StResp);
    mem_valid_d      = (state_d == StWriteback) || (state_d == StRefillReq);
    mem_rd_wr_d      = (state_d == StWriteback);
    mem_read_ready_d = (state_d == StRefillWait);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      rd_wr_q          <= 1'b0;
      laddr_q          <= '0;
      wdata_q          <= '0;
      victim_q         <= 1'b0;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      mem_valid_q      <= 1'b0;
      mem_rd_wr_q      <= 1'b0;
      mem_read_ready_q <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      resp_data_q      <= '0;
      hit_cnt_q        <= '0;
      miss_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      rd_wr_q          <= rd_wr_d;
      laddr_q          <= laddr_d;
      wdata_q          <= wdata_d;
      victim_q         <= victim_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      mem_valid_q      <= mem_valid_d;
      mem_rd_wr_q      <= mem_rd_wr_d;
      mem_read_ready_q <= mem_read_ready_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      resp_data_q      <= resp_data_d;
      hit_cnt_q        <= hit_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < 2; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < NumSets; s++) tag_q[w][s] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (upd_en) begin
        tag_q[upd_way][req_set]   <= req_tag;
        valid_q[upd_way][req_set] <= 1'b1;
        dirty_q[upd_way][req_set] <= upd_dirty;
      end
      if (lru_en) lru_q[req_set] <= ~lru_way;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en) data_q[upd_way][req_set] <= upd_data;
  end

  assign o_cpu_req_ready  = req_ready_q;
  assign o_cpu_resp_valid = resp_valid_q;
  assign o_cpu_read_data  = resp_data_q;
  assign o_mem_valid      = mem_valid_q;
  assign o_mem_rd_wr      = mem_rd_wr_q;
  assign o_mem_address    = mem_addr_q;
  assign o_mem_write_data = mem_wdata_q;
  assign o_mem_read_ready = mem_read_ready_q;
  assign o_hit_count      = hit_cnt_q;
  assign o_miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_sa2_wb_cache.sv
// Scoreboard bench for sa2_wb_cache: a line-level golden memory plus per-set recency model predicts
// responses, counters and memory traffic; separate CPU and memory monitors pop and compare.
module tb_sa2_wb_cache;
  localparam int AW = 64;
  localparam int LB = 512;
  localparam int CW = 4;
  localparam int Bound = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_cpu_req_valid, o_cpu_req_ready, i_cpu_rd_wr;
  logic [AW-1:0] i_cpu_address;
  logic [LB-1:0] i_cpu_write_data, o_cpu_read_data;
  logic          o_cpu_resp_valid, i_cpu_resp_ready;
  logic          o_mem_valid, i_mem_ready, o_mem_rd_wr;
  logic [AW-1:0] o_mem_address;
  logic [LB-1:0] o_mem_write_data, i_mem_read_data;
  logic          i_mem_read_valid, o_mem_read_ready;
  logic [CW-1:0] o_hit_count, o_miss_count;

  sa2_wb_cache #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req_valid(i_cpu_req_valid), .o_cpu_req_ready(o_cpu_req_ready),
    .i_cpu_rd_wr(i_cpu_rd_wr), .i_cpu_address(i_cpu_address),
    .i_cpu_write_data(i_cpu_write_data), .o_cpu_resp_valid(o_cpu_resp_valid),
    .i_cpu_resp_ready(i_cpu_resp_ready), .o_cpu_read_data(o_cpu_read_data),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_rd_wr(o_mem_rd_wr),
    .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
    .i_mem_read_valid(i_mem_read_valid), .o_mem_read_ready(o_mem_read_ready),
    .i_mem_read_data(i_mem_read_data), .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
  );

  typedef struct { logic [LB-1:0] data; int hits; int misses; } resp_t;
  typedef struct { bit wr; logic [AW-1:0] addr; logic [LB-1:0] data; } memop_t;

  resp_t         exp_resp[$];
  memop_t        exp_mem[$];
  logic [LB-1:0] gold [logic [AW-1:0]];
  logic [LB-1:0] mem_store [logic [AW-1:0]];
  bit            dirty_m [logic [AW-1:0]];
  logic [AW-1:0] mru [8];
  logic [AW-1:0] lru [8];
  int            occ [8];
  int            hits_m, misses_m, errors, checks, issued, served;
  bit            mem_hold, refill_hold, resp_hold;

  task automatic chk(input string name, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [LB-1:0] init_line(input logic [AW-1:0] la);
    logic [LB-1:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = la ^ (64'h0123_4567_89AB_CDEF * 64'(i + 1));
    return l;
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [LB-1:0] gold_val(input logic [AW-1:0] la);
    return gold.exists(la) ? gold[la] : init_line(la);
  endfunction

  function automatic logic [LB-1:0] mem_val(input logic [AW-1:0] la);
    return mem_store.exists(la) ? mem_store[la] : init_line(la);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) occ[s] = 0;
    dirty_m.delete();
    gold = mem_store;
    hits_m = 0;
    misses_m = 0;
  endtask

  // Recency list per set: mru is the most recent line, lru the one to evict when the set is full.
  task automatic model(input bit rw, input logic [AW-1:0] addr, input logic [LB-1:0] wd);
    logic [AW-1:0] la, vic;
    int s;
    bit is_hit;
    resp_t r;
    memop_t op;
    la = addr & ~64'h3F;
    s = int'(la[8:6]);
    is_hit = 1'b0;
    if (occ[s] > 0 && mru[s] == la) is_hit = 1'b1;
    else if (occ[s] == 2 && lru[s] == la) begin
      is_hit = 1'b1;
      lru[s] = mru[s];
      mru[s] = la;
    end else begin
      if (occ[s] == 2) begin
        vic = lru[s];
        if (dirty_m.exists(vic) && dirty_m[vic]) begin
          op.wr = 1'b1; op.addr = vic; op.data = gold_val(vic);
          exp_mem.push_back(op);
        end
        dirty_m[vic] = 1'b0;
      end
      if (occ[s] > 0) lru[s] = mru[s];
      mru[s] = la;
      if (occ[s] < 2) occ[s]++;
      if (!rw) begin
        op.wr = 1'b0; op.addr = la; op.data = '0;
        exp_mem.push_back(op);
      end
    end
    if (is_hit) hits_m = (hits_m < 15) ? hits_m + 1 : 15;
    else misses_m = (misses_m < 15) ? misses_m + 1 : 15;
    if (rw) begin
      gold[la] = wd;
      dirty_m[la] = 1'b1;
    end
    r.data = rw ? wd : gold_val(la);
    r.hits = hits_m;
    r.misses = misses_m;
    exp_resp.push_back(r);
  endtask

  task automatic issue(input bit rw, input logic [AW-1:0] addr, input logic [LB-1:0] wd);
    int n = 0;
    while (!o_cpu_req_ready && n < Bound) begin @(negedge clk); n++; end
    if (n >= Bound) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: req_ready never rose within %0d cycles", Bound);
      return;
    end
    model(rw, addr, wd);
    i_cpu_req_valid = 1'b1;
    i_cpu_rd_wr = rw;
    i_cpu_address = addr;
    i_cpu_write_data = wd;
    issued++;
    @(negedge clk);
    i_cpu_req_valid = 1'b0;
    i_cpu_write_data = rand_line();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((served != issued || !o_cpu_req_ready) && n < Bound) begin @(negedge clk); n++; end
    chk({name, "_done"}, LB'(n < Bound), LB'(1));
    chk({name, "_memq_empty"}, LB'(exp_mem.size()), LB'(0));
  endtask

  // Memory side: random accept delay, golden backing store, expected-traffic scoreboard.
  initial begin
    bit pending;
    logic [AW-1:0] paddr;
    memop_t e;
    pending = 1'b0;
    paddr = '0;
    i_mem_ready = 1'b0;
    i_mem_read_valid = 1'b0;
    i_mem_read_data = '0;
    forever begin
      @(negedge clk);
      i_mem_ready = 1'b0;
      i_mem_read_valid = 1'b0;
      if (!rst_n) pending = 1'b0;
      else begin
        if (o_mem_valid && !mem_hold && $urandom_range(0, 3) != 0) begin
          i_mem_ready = 1'b1;
          if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: rd_wr=%0b addr=%0h with no memory op expected",
                     o_mem_rd_wr, o_mem_address);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_rd_wr", LB'(o_mem_rd_wr), LB'(e.wr));
            chk("mem_addr", LB'(o_mem_address), LB'(e.addr));
            if (e.wr) chk("mem_wb_data", o_mem_write_data, e.data);
          end
          if (o_mem_rd_wr) mem_store[o_mem_address] = o_mem_write_data;
          else begin
            pending = 1'b1;
            paddr = o_mem_address;
          end
        end
        if (pending && o_mem_read_ready && !refill_hold && $urandom_range(0, 2) != 0) begin
          i_mem_read_valid = 1'b1;
          i_mem_read_data = mem_val(paddr);
          pending = 1'b0;
        end
      end
    end
  end

  // CPU response monitor.
  initial begin
    resp_t e;
    i_cpu_resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      i_cpu_resp_ready = 1'b0;
      if (rst_n && o_cpu_resp_valid && !resp_hold && $urandom_range(0, 2) != 0) begin
        i_cpu_resp_ready = 1'b1;
        if (exp_resp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: data=%0h with no response expected", o_cpu_read_data);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_data", o_cpu_read_data, e.data);
          chk("resp_hit_count", LB'(o_hit_count), LB'(e.hits));
          chk("resp_miss_count", LB'(o_miss_count), LB'(e.misses));
        end
        served++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] s_addr;
    logic [LB-1:0] s_data;
    logic          s_rw;
    int n;
    errors = 0; checks = 0; issued = 0; served = 0;
    mem_hold = 0; refill_hold = 0; resp_hold = 0;
    i_cpu_req_valid = 0; i_cpu_rd_wr = 0; i_cpu_address = '0; i_cpu_write_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", LB'(o_cpu_req_ready), LB'(0));
    chk("rst_resp_valid", LB'(o_cpu_resp_valid), LB'(0));
    chk("rst_mem_valid", LB'(o_mem_valid), LB'(0));
    chk("rst_read_data", o_cpu_read_data, LB'(0));
    chk("rst_counts", LB'({o_hit_count, o_miss_count}), LB'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", LB'(o_cpu_req_ready), LB'(1));

    issue(0, 64'h1040, rand_line());
    wait_idle("cold_read");
    issue(0, 64'h1040, rand_line());
    chk("hit_lat_t1", LB'(o_cpu_resp_valid), LB'(0));
    @(negedge clk);
    chk("hit_lat_t2", LB'(o_cpu_resp_valid), LB'(1));
    wait_idle("reread_hit");
    issue(1, 64'h1240, rand_line());
    wait_idle("write_miss");
    issue(0, 64'h1040, rand_line());
    wait_idle("still_hit");
    issue(0, 64'h1240, rand_line());
    issue(0, 64'h1440, rand_line());
    wait_idle("clean_evict");
    issue(0, 64'h1640, rand_line());
    wait_idle("dirty_evict");
    issue(0, 64'h1440, rand_line());
    wait_idle("hit_after_evict");
    chk("dir_hit_count", LB'(o_hit_count), LB'(4));
    chk("dir_miss_count", LB'(o_miss_count), LB'(4));

    mem_hold = 1; resp_hold = 1;
    issue(0, 64'h2000, rand_line());
    n = 0;
    while (!o_mem_valid && n < Bound) begin @(negedge clk); n++; end
    chk("bp_mem_seen", LB'(o_mem_valid), LB'(1));
    s_addr = o_mem_address; s_rw = o_mem_rd_wr;
    repeat (5) begin
      @(negedge clk);
      chk("bp_mem_valid", LB'(o_mem_valid), LB'(1));
      chk("bp_mem_addr", LB'(o_mem_address), LB'(s_addr));
      chk("bp_mem_rd_wr", LB'(o_mem_rd_wr), LB'(s_rw));
      chk("bp_req_ready", LB'(o_cpu_req_ready), LB'(0));
    end
    mem_hold = 0;
    n = 0;
    while (!o_cpu_resp_valid && n < Bound) begin @(negedge clk); n++; end
    chk("bp_resp_seen", LB'(o_cpu_resp_valid), LB'(1));
    s_data = o_cpu_read_data;
    repeat (5) begin
      @(negedge clk);
      chk("bp_resp_valid", LB'(o_cpu_resp_valid), LB'(1));
      chk("bp_resp_data", o_cpu_read_data, s_data);
      chk("bp_req_ready2", LB'(o_cpu_req_ready), LB'(0));
    end
    resp_hold = 0;
    wait_idle("backpressure");

    refill_hold = 1;
    issue(0, 64'h3000, rand_line());
    n = 0;
    while (!o_mem_read_ready && n < Bound) begin @(negedge clk); n++; end
    chk("rst_wait_seen", LB'(o_mem_read_ready), LB'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_read_ready", LB'(o_mem_read_ready), LB'(0));
    chk("mid_rst_req_ready", LB'(o_cpu_req_ready), LB'(0));
    chk("mid_rst_valids", LB'({o_cpu_resp_valid, o_mem_valid, o_mem_rd_wr}), LB'(0));
    chk("mid_rst_addr", LB'(o_mem_address), LB'(0));
    chk("mid_rst_counts", LB'({o_hit_count, o_miss_count}), LB'(0));
    exp_resp.delete();
    exp_mem.delete();
    issued = 0; served = 0;
    model_reset();
    repeat (2) @(negedge clk);
    refill_hold = 0;
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 64'h1040, rand_line());
    wait_idle("after_reset");
    chk("after_rst_miss", LB'(o_miss_count), LB'(1));
    for (int i = 0; i < 20; i++) issue(0, 64'h1040, rand_line());
    wait_idle("sat_hits");
    chk("hit_saturated", LB'(o_hit_count), LB'(15));

    for (int i = 0; i < 250; i++) begin
      s_addr = (64'($urandom_range(8, 13)) << 9) | (64'($urandom_range(0, 3)) << 6) |
               64'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), s_addr, rand_line());
    end
    wait_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
